adc_acq_ctrl: RTL and testbench
===============================

# adc_acq_ctrl

Acquisition controller for the oscilloscope front end. It paces conversions on the 12-bit SPI ADC reader at a programmable sample rate and detects an edge trigger on the returned samples. It writes samples into a circular capture RAM so that a fixed number of pre-trigger samples are retained. It sits between the ADC reader, the capture RAM and the display/readout logic, which sees only the status outputs.

## Interface
- `DATA_W`, 12: ADC sample width.
- `ADDR_W`, 10: capture RAM address width; DEPTH = 2^ADDR_W.
- `DIV_W`, 16: sample-period divider width.

- `clk` in 1: single system clock; all logic is on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `arm` in 1: one-cycle pulse that starts a capture; accepted in IDLE or DONE only.
- `abort` in 1: forces IDLE from any state.
- `chan` in 3: ADC channel; latched on accepted `arm`.
- `rate_div` in DIV_W: sample period minus 1, in `clk` cycles; latched on `arm`.
- `trig_level` in DATA_W: trigger threshold, unsigned; latched on `arm`.
- `trig_edge` in 1: 0 = rising, 1 = falling; latched on `arm`.
- `pretrig` in ADDR_W: pre-trigger sample count P; latched on `arm`, clamped to DEPTH-1.
- `force_trig` in 1: pulse that forces a trigger on the next sample written in WAIT_TRIG.
- `conv_start` out 1: one-cycle pulse requesting a conversion from the ADC reader.
- `conv_chan` out 3: latched channel.
- `conv_done` in 1: one-cycle pulse; `conv_data` is valid in the same cycle.
- `conv_data` in DATA_W: conversion result.
- `wr_en` out 1, `wr_addr` out ADDR_W, `wr_data` out DATA_W: capture RAM write port.
- `busy` out 1: high in PRETRIG, WAIT_TRIG and POST.
- `triggered` out 1: sticky; set on the trigger sample, cleared on `arm`/`abort`.
- `capture_done` out 1: high in DONE.
- `trig_addr` out ADDR_W: RAM address of the trigger sample.
- `overrun` out 1: sticky; a sample tick was dropped. Cleared on `arm`.

## Operation
- **Reset values:** all outputs are 0. State is IDLE; the divider and both address counters are 0; the previous-sample-valid flag is clear.
- **States:**
  - IDLE: no ticks. An accepted `arm` latches the configuration, clears `wr_addr` and the status outputs, and moves to PRETRIG, or to WAIT_TRIG if P = 0.
  - PRETRIG: writes samples. After P writes, moves to WAIT_TRIG. No trigger evaluation.
  - WAIT_TRIG: writes samples circularly, with `wr_addr` wrapping DEPTH-1 → 0. Each written sample is evaluated for the trigger. A trigger moves to POST, or to DONE if DEPTH-1-P = 0.
  - POST: writes DEPTH-1-P further samples, then moves to DONE.
  - DONE: no ticks; `capture_done` = 1. `arm` restarts the capture as from IDLE.
- **Tick generator:**
  - A down-counter loads `rate_div` on `arm`; first `conv_start` is one cycle after `arm`.
  - Every rate_div+1 cycles thereafter while `busy`.
  - A conversion is outstanding from `conv_start` until `conv_done`. A tick while outstanding emits no `conv_start` and sets `overrun`.
  - A tick coinciding with `conv_done` is not an overrun.
- **Trigger rules:**
  - Rising: prev < level and cur >= level. Falling: prev > level and cur <= level.
  - prev is the last written sample, tracked from the first sample after `arm`. The first sample of a capture can never trigger.
  - `force_trig` sets a pending flag that is honoured on the next written sample in WAIT_TRIG. A forced and a level trigger on the same sample count as one trigger.
  - `force_trig` outside WAIT_TRIG is ignored and not held.
- **Buffer layout at DONE:**
  - The oldest sample is at `wr_addr` (final) = (trig_addr − P) mod DEPTH.
  - Readout runs DEPTH samples from there, with the trigger at offset P.
- **Abort and stray results:**
  - `abort` has priority over `arm` in the same cycle. It goes to IDLE next cycle; `capture_done` stays 0 and `triggered` is cleared.
  - A `conv_done` received in IDLE or DONE is ignored and produces no write.

## Timing
- `conv_done` at cycle n gives `wr_en` = 1 at n+1, with `wr_data` equal to the registered `conv_data` and `wr_addr` the current address. `wr_addr` increments at n+2.
- For the trigger sample, `triggered` and `trig_addr` update in the same cycle as its `wr_en`.
- The state change to POST or DONE takes effect on the cycle after the triggering or final write.
- `capture_done` rises one cycle after the last POST write.
- `conv_chan` is constant for a whole capture.

## Test plan
- **Basic capture:** ADDR_W=4, P=4, rate_div=9, rising, level=0x800, ramp model 0x100 step 0x100 → trigger on sample 0x800. Then 11 post writes; `trig_addr` = 7, final `wr_addr` = 3, `capture_done` set.
- **Pacing:** rate_div=9 → `conv_start` pulses exactly 10 cycles apart, first one 1 cycle after `arm`.
- **Overrun:** model latency 15 cycles, rate_div=9 → alternate ticks dropped, `overrun` = 1, writes every 20 cycles.
- **Force trigger:** flat input 0x400 with `force_trig` in WAIT_TRIG → the next written sample triggers. `force_trig` in PRETRIG → no effect.
- **Boundary P:** P=15 → DONE on the trigger-sample write cycle +1. P=0 → enters WAIT_TRIG directly; first sample does not trigger.
- **Abort and reset:** `abort` mid-POST → IDLE, `busy` = 0, `capture_done` = 0, and a late `conv_done` produces no `wr_en`. Async `rst_n` low mid-capture → all outputs 0 immediately.

Source files
------------

// File: rtl/adc_acq_ctrl.sv
// Oscilloscope acquisition controller: paces ADC conversions, detects an edge
// trigger and fills a circular capture RAM keeping P pre-trigger samples.
module adc_acq_ctrl #(
  parameter int DATA_W = 12,
  parameter int ADDR_W = 10,
  parameter int DIV_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              arm,
  input  logic              abort,
  input  logic [2:0]        chan,
  input  logic [DIV_W-1:0]  rate_div,
  input  logic [DATA_W-1:0] trig_level,
  input  logic              trig_edge,
  input  logic [ADDR_W-1:0] pretrig,
  input  logic              force_trig,
  output logic              conv_start,
  output logic [2:0]        conv_chan,
  input  logic              conv_done,
  input  logic [DATA_W-1:0] conv_data,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              busy,
  output logic              triggered,
  output logic              capture_done,
  output logic [ADDR_W-1:0] trig_addr,
  output logic              overrun
);

  typedef enum logic [2:0] {IDLE, PRETRIG, WAIT_TRIG, POST, DONE} state_e;

  state_e            state_q;
  logic [DIV_W-1:0]  div_q, rate_q;
  logic [DATA_W-1:0] level_q, prev_q, wr_data_q;
  logic              edge_q, prev_vld_q, force_pend_q, pend_q;
  logic [ADDR_W-1:0] p_q, cnt_q, wr_addr_q, trig_addr_q;
  logic [2:0]        chan_q;
  logic              conv_start_q, wr_en_q, busy_q, trig_q, done_q, ovr_q;

  logic              active, arm_ok, sample, rise, fall, lvl_hit, hit, leave;
  logic [ADDR_W-1:0] cnt_nx, post_len;

  assign active   = (state_q == PRETRIG) || (state_q == WAIT_TRIG) || (state_q == POST);
  assign arm_ok   = arm && !abort && ((state_q == IDLE) || (state_q == DONE));
  assign sample   = conv_done && active;
  assign cnt_nx   = cnt_q + 1'b1;
  assign post_len = {ADDR_W{1'b1}} - p_q;

  assign rise    = (prev_q < level_q) && (conv_data >= level_q);
  assign fall    = (prev_q > level_q) && (conv_data <= level_q);
  assign lvl_hit = prev_vld_q && (edge_q ? fall : rise);
  // Level and forced triggers on the same sample collapse into one hit.
  assign hit     = sample && (state_q == WAIT_TRIG) && !trig_q &&
                   (lvl_hit || force_pend_q || force_trig);

  // Final write of the capture: no further tick may be issued on this edge.
  assign leave = wr_en_q &&
                 (((state_q == WAIT_TRIG) && trig_q && (post_len == '0)) ||
                  ((state_q == POST) && (cnt_nx == post_len)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      div_q        <= '0;
      rate_q       <= '0;
      level_q      <= '0;
      prev_q       <= '0;
      wr_data_q    <= '0;
      edge_q       <= 1'b0;
      prev_vld_q   <= 1'b0;
      force_pend_q <= 1'b0;
      pend_q       <= 1'b0;
      p_q          <= '0;
      cnt_q        <= '0;
      wr_addr_q    <= '0;
      trig_addr_q  <= '0;
      chan_q       <= '0;
      conv_start_q <= 1'b0;
      wr_en_q      <= 1'b0;
      busy_q       <= 1'b0;
      trig_q       <= 1'b0;
      done_q       <= 1'b0;
      ovr_q        <= 1'b0;
    end else begin
      conv_start_q <= 1'b0;
      wr_en_q      <= 1'b0;
      if (conv_done) pend_q <= 1'b0;
      if (abort) begin
        state_q      <= IDLE;
        busy_q       <= 1'b0;
        done_q       <= 1'b0;
        trig_q       <= 1'b0;
        force_pend_q <= 1'b0;
        pend_q       <= 1'b0;
      end else if (arm_ok) begin
        // pretrig is ADDR_W wide, so it can never exceed DEPTH-1.
        rate_q       <= rate_div;
        div_q        <= rate_div;
        level_q      <= trig_level;
        edge_q       <= trig_edge;
        p_q          <= pretrig;
        chan_q       <= chan;
        conv_start_q <= 1'b1;
        pend_q       <= 1'b1;
        wr_addr_q    <= '0;
        cnt_q        <= '0;
        trig_q       <= 1'b0;
        trig_addr_q  <= '0;
        ovr_q        <= 1'b0;
        done_q       <= 1'b0;
        busy_q       <= 1'b1;
        prev_vld_q   <= 1'b0;
        force_pend_q <= 1'b0;
        state_q      <= (pretrig == '0) ? WAIT_TRIG : PRETRIG;
      end else if (active) begin
        if (div_q == '0) begin
          div_q <= rate_q;
          if (!leave) begin
            // A result arriving on the tick frees the reader for the new request.
            if (!pend_q || conv_done) begin
              conv_start_q <= 1'b1;
              pend_q       <= 1'b1;
            end else begin
              ovr_q <= 1'b1;
            end
          end
        end else begin
          div_q <= div_q - 1'b1;
        end

        if (sample) begin
          wr_en_q    <= 1'b1;
          wr_data_q  <= conv_data;
          prev_q     <= conv_data;
          prev_vld_q <= 1'b1;
        end
        if (hit) begin
          trig_q      <= 1'b1;
          trig_addr_q <= wr_addr_q;
        end

        if (state_q == WAIT_TRIG) force_pend_q <= (force_pend_q || force_trig) && !sample;
        else                      force_pend_q <= 1'b0;

        if (wr_en_q) begin
          wr_addr_q <= wr_addr_q + 1'b1;
          case (state_q)
            PRETRIG: begin
              if (cnt_nx == p_q) begin
                state_q <= WAIT_TRIG;
                cnt_q   <= '0;
              end else begin
                cnt_q <= cnt_nx;
              end
            end
            WAIT_TRIG: begin
              if (trig_q) begin
                cnt_q <= '0;
                if (leave) begin
                  state_q <= DONE;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                end else begin
                  state_q <= POST;
                end
              end
            end
            POST: begin
              if (leave) begin
                state_q <= DONE;
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
              end else begin
                cnt_q <= cnt_nx;
              end
            end
            default: ;
          endcase
        end
      end
    end
  end

  assign conv_start   = conv_start_q;
  assign conv_chan    = chan_q;
  assign wr_en        = wr_en_q;
  assign wr_addr      = wr_addr_q;
  assign wr_data      = wr_data_q;
  assign busy         = busy_q;
  assign triggered    = trig_q;
  assign capture_done = done_q;
  assign trig_addr    = trig_addr_q;
  assign overrun      = ovr_q;

endmodule

// File: tb/tb_adc_acq_ctrl.sv
// Directed bench for adc_acq_ctrl with a 16-deep buffer and a latency-driven
// ADC model producing ramp or flat samples.
module tb_adc_acq_ctrl;
  localparam int DW = 12;
  localparam int AW = 4;
  localparam int VW = 16;

  logic          clk, rst_n, arm, abort, trig_edge, force_trig, conv_done;
  logic [2:0]    chan, conv_chan;
  logic [VW-1:0] rate_div;
  logic [DW-1:0] trig_level, conv_data, wr_data;
  logic [AW-1:0] pretrig, wr_addr, trig_addr;
  logic          conv_start, wr_en, busy, triggered, capture_done, overrun;

  adc_acq_ctrl #(.DATA_W(DW), .ADDR_W(AW), .DIV_W(VW)) dut (
    .clk(clk), .rst_n(rst_n), .arm(arm), .abort(abort), .chan(chan),
    .rate_div(rate_div), .trig_level(trig_level), .trig_edge(trig_edge),
    .pretrig(pretrig), .force_trig(force_trig), .conv_start(conv_start),
    .conv_chan(conv_chan), .conv_done(conv_done), .conv_data(conv_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy),
    .triggered(triggered), .capture_done(capture_done), .trig_addr(trig_addr),
    .overrun(overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [28:0] outs;
  assign outs = {conv_start, conv_chan, wr_en, wr_addr, wr_data, busy,
                 triggered, capture_done, trig_addr, overrun};

  // ADC model: conv_done arrives lat cycles after conv_start, data = base + step*idx
  int          lat = 3;
  int          mcnt = 0;
  logic [11:0] mbase = 12'h100, mstep = 12'h100, midx = '0;
  initial begin
    conv_done = 1'b0;
    conv_data = '0;
    forever begin
      @(negedge clk);
      conv_done = 1'b0;
      if (arm) midx = '0;
      if (mcnt > 0) begin
        mcnt--;
        if (mcnt == 0) begin
          conv_done = 1'b1;
          conv_data = mbase + mstep * midx;
          midx++;
        end
      end
      if (conv_start) mcnt = lat;
    end
  end

  // Event monitor
  int          wrcnt = 0, st_prev = 0, st_last = 0, wr_prev = 0, wr_last = 0;
  int          trig_cyc = 0, done_cyc = 0;
  logic        trig_wr = 1'b0, trig_d = 1'b0, done_d = 1'b0;
  logic [11:0] trig_data = '0;
  initial forever begin
    @(negedge clk);
    if (conv_start) begin st_prev = st_last; st_last = cyc; end
    if (wr_en) begin wrcnt++; wr_prev = wr_last; wr_last = cyc; end
    if (triggered && !trig_d) begin trig_cyc = cyc; trig_wr = wr_en; trig_data = wr_data; end
    if (capture_done && !done_d) done_cyc = cyc;
    trig_d = triggered;
    done_d = capture_done;
  end

  int nchk = 0, nfail = 0;
  int arm_cyc, base, sl;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nfail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic do_arm(input int p, input int rate, input int lvl, input logic edg, input int ch);
    pretrig    = AW'(p);
    rate_div   = VW'(rate);
    trig_level = DW'(lvl);
    trig_edge  = edg;
    chan       = 3'(ch);
    arm        = 1'b1;
    arm_cyc    = cyc;
    tick();
    arm        = 1'b0;
  endtask

  task automatic wait_wr(input int target, input string tag);
    for (int i = 0; i < 1000 && wrcnt < target; i++) tick();
    chk(tag, 32'(wrcnt >= target), 1);
  endtask

  task automatic wait_done(input string tag);
    for (int i = 0; i < 2000 && !capture_done; i++) tick();
    chk(tag, 32'(capture_done), 1);
  endtask

  initial begin
    rst_n = 1'b0; arm = 1'b0; abort = 1'b0; force_trig = 1'b0;
    chan = '0; rate_div = '0; trig_level = '0; trig_edge = 1'b0; pretrig = '0;
    repeat (3) tick();
    chk("reset_outs", 32'(outs), 0);
    rst_n = 1'b1;
    tick();

    // Basic capture: P=4, ramp, rising at 0x800
    lat = 3; mbase = 12'h100; mstep = 12'h100;
    base = wrcnt;
    do_arm(4, 9, 12'h800, 1'b0, 5);
    repeat (14) tick();
    chk("first_start", 32'(st_prev - arm_cyc), 1);
    chk("start_period", 32'(st_last - st_prev), 10);
    wait_done("basic_done");
    chk("basic_trig_addr", 32'(trig_addr), 7);
    chk("basic_final_addr", 32'(wr_addr), 3);
    chk("basic_triggered", 32'(triggered), 1);
    chk("basic_trig_data", 32'(trig_data), 12'h800);
    chk("basic_trig_with_wr", 32'(trig_wr), 1);
    chk("basic_writes", 32'(wrcnt - base), 19);
    chk("basic_chan", 32'(conv_chan), 5);
    chk("basic_busy", 32'(busy), 0);

    // Overrun: latency 15 vs period 10
    lat = 15;
    do_arm(2, 9, 12'hFFF, 1'b0, 1);
    repeat (100) tick();
    chk("ovr_flag", 32'(overrun), 1);
    chk("ovr_wr_period", 32'(wr_last - wr_prev), 20);
    chk("ovr_start_period", 32'(st_last - st_prev), 20);
    abort = 1'b1; tick(); abort = 1'b0;
    repeat (30) tick();

    // Force trigger: ignored in PRETRIG, honoured in WAIT_TRIG
    lat = 3; mbase = 12'h400; mstep = 12'h000;
    base = wrcnt;
    do_arm(2, 9, 12'h800, 1'b0, 3);
    chk("ovr_cleared", 32'(overrun), 0);
    tick();
    force_trig = 1'b1; tick(); force_trig = 1'b0;
    wait_wr(base + 4, "force_wr4");
    chk("force_pretrig_ignored", 32'(triggered), 0);
    force_trig = 1'b1; tick(); force_trig = 1'b0;
    wait_done("force_done");
    chk("force_trig_addr", 32'(trig_addr), 4);
    chk("force_final_addr", 32'(wr_addr), 2);
    chk("force_trig_data", 32'(trig_data), 12'h400);

    // Boundary P=15: DONE one cycle after the trigger write
    mbase = 12'h100; mstep = 12'h100;
    base = wrcnt;
    do_arm(15, 4, 12'h800, 1'b0, 2);
    wait_done("p15_done");
    chk("p15_done_timing", 32'(done_cyc - trig_cyc), 1);
    chk("p15_trig_addr", 32'(trig_addr), 7);
    chk("p15_final_addr", 32'(wr_addr), 8);
    chk("p15_writes", 32'(wrcnt - base), 24);
    chk("p15_chan", 32'(conv_chan), 2);

    // Boundary P=0: first sample (above level) must not trigger
    mbase = 12'h900; mstep = 12'h000;
    base = wrcnt;
    do_arm(0, 9, 12'h800, 1'b0, 0);
    chk("p0_busy", 32'(busy), 1);
    wait_wr(base + 3, "p0_wr3");
    chk("p0_no_trig", 32'(triggered), 0);
    abort = 1'b1; tick(); abort = 1'b0;
    chk("p0_abort_busy", 32'(busy), 0);
    repeat (10) tick();

    // P=0 with force right after arm: first sample is in WAIT_TRIG
    base = wrcnt;
    do_arm(0, 9, 12'h800, 1'b0, 0);
    force_trig = 1'b1; tick(); force_trig = 1'b0;
    wait_done("p0f_done");
    chk("p0f_trig_addr", 32'(trig_addr), 0);
    chk("p0f_final_addr", 32'(wr_addr), 0);
    chk("p0f_writes", 32'(wrcnt - base), 16);

    // Abort mid-POST with a conversion outstanding
    mbase = 12'h100; mstep = 12'h100;
    do_arm(4, 9, 12'h800, 1'b0, 6);
    for (int i = 0; i < 1000 && !(triggered && conv_start); i++) tick();
    chk("abort_reach_post", 32'(triggered && conv_start), 1);
    abort = 1'b1; tick(); abort = 1'b0;
    chk("abort_busy", 32'(busy), 0);
    chk("abort_done", 32'(capture_done), 0);
    chk("abort_trig", 32'(triggered), 0);
    base = wrcnt; sl = st_last;
    repeat (20) tick();
    chk("abort_no_wr", 32'(wrcnt - base), 0);
    chk("abort_no_start", 32'(st_last - sl), 0);

    // Async reset mid-capture
    base = wrcnt;
    do_arm(4, 9, 12'h800, 1'b0, 7);
    wait_wr(base + 5, "rst_wr5");
    chk("pre_rst_busy", 32'(busy), 1);
    #2 rst_n = 1'b0;
    #1 chk("async_rst_outs", 32'(outs), 0);
    repeat (2) tick();
    rst_n = 1'b1;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
    $finish;
  end
endmodule
